// File: rtl/usb_rx_pkg.sv
// rtl/usb_rx_pkg.sv - shared types and constants for the USB full-speed receive controller
package usb_rx_pkg;

   typedef enum logic [2:0] {
      IDLE,
      SYNC,
      RECEIVE,
      EOP_WAIT,
      ERROR
   } rx_state_t;

   // Line state encoded as {d_plus, d_minus}
   typedef enum logic [1:0] {
      LINE_SE0 = 2'b00,
      LINE_K   = 2'b01,
      LINE_J   = 2'b10,
      LINE_SE1 = 2'b11
   } line_state_t;

   localparam logic [7:0] SYNC_PATTERN = 8'h80;
   localparam logic [2:0] STUFF_LIMIT  = 3'd6;

endpackage

// File: rtl/usb_rx_timer.sv
// rtl/usb_rx_timer.sv - D+ edge detector, bit timer and decoder sample strobe
module usb_rx_timer #(
   parameter int CLKS_PER_BIT = 8,
   parameter int SAMPLE_POINT = 3
) (
   input  logic clk,
   input  logic rst,
   input  logic run_i,
   input  logic d_plus_i,
   output logic shift_en_o,
   output logic d_plus_prev_o
);

   localparam int TW = $clog2(CLKS_PER_BIT);
   localparam logic [TW-1:0] LAST_CNT   = TW'(CLKS_PER_BIT - 1);
   localparam logic [TW-1:0] SAMPLE_CNT = TW'(SAMPLE_POINT);

   logic [TW-1:0] timer_q, timer_d;
   logic          d_plus_prev_q;
   logic          edge_det;

   assign edge_det      = (d_plus_i != d_plus_prev_q);
   assign d_plus_prev_o = d_plus_prev_q;

   // Every D+ transition re-aligns the timer so the sample stays mid-bit under jitter
   always_comb begin
      timer_d = timer_q;
      if (!run_i || edge_det) begin
         timer_d = '0;
      end else if (timer_q == LAST_CNT) begin
         timer_d = '0;
      end else begin
         timer_d = timer_q + TW'(1);
      end
   end

   assign shift_en_o = run_i && (timer_q == SAMPLE_CNT) && !edge_det;

   always_ff @(posedge clk) begin
      if (rst) begin
         timer_q       <= '0;
         d_plus_prev_q <= 1'b1;
      end else begin
         timer_q       <= timer_d;
         d_plus_prev_q <= d_plus_i;
      end
   end

endmodule

// File: rtl/usb_rx_controller.sv
// rtl/usb_rx_controller.sv - USB FS receive sequencer: SYNC detect, unstuffing, byte assembly
module usb_rx_controller
   import usb_rx_pkg::*;
#(
   parameter int CLKS_PER_BIT = 8,
   parameter int SAMPLE_POINT = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       d_plus_sync,
   input  logic       d_minus_sync,
   input  logic       d_orig,
   output logic       shift_en,
   output logic       eop,
   output logic [7:0] rcv_data,
   output logic       byte_valid,
   output logic       receiving,
   output logic       packet_done,
   output logic       rx_error
);

   rx_state_t   state_q, state_d;
   line_state_t line;
   logic [7:0]  sr_q, sr_d;
   logic [7:0]  rcv_data_q, rcv_data_d;
   logic [2:0]  bit_cnt_q, bit_cnt_d;
   logic [2:0]  ones_cnt_q, ones_cnt_d;
   logic        byte_valid_q, byte_valid_d;
   logic        packet_done_q, packet_done_d;
   logic        rx_error_q, rx_error_d;
   logic        se0_seen_q, se0_seen_d;
   logic        shift_d1_q, eop_d1_q;
   logic        d_plus_prev;
   logic [7:0]  sr_shift;

   usb_rx_timer #(
      .CLKS_PER_BIT (CLKS_PER_BIT),
      .SAMPLE_POINT (SAMPLE_POINT)
   ) u_timer (
      .clk           (clk),
      .rst           (rst),
      .run_i         (state_q != IDLE),
      .d_plus_i      (d_plus_sync),
      .shift_en_o    (shift_en),
      .d_plus_prev_o (d_plus_prev)
   );

   assign line        = line_state_t'({d_plus_sync, d_minus_sync});
   assign eop         = ~d_plus_sync & ~d_minus_sync;
   assign sr_shift    = {d_orig, sr_q[7:1]};
   assign rcv_data    = rcv_data_q;
   assign byte_valid  = byte_valid_q;
   assign packet_done = packet_done_q;
   assign rx_error    = rx_error_q;
   assign receiving   = (state_q == SYNC) || (state_q == RECEIVE) || (state_q == EOP_WAIT);

   always_comb begin
      state_d       = state_q;
      sr_d          = sr_q;
      rcv_data_d    = rcv_data_q;
      bit_cnt_d     = bit_cnt_q;
      ones_cnt_d    = ones_cnt_q;
      byte_valid_d  = 1'b0;
      packet_done_d = 1'b0;
      rx_error_d    = rx_error_q;
      se0_seen_d    = se0_seen_q;

      if (state_q != IDLE && line == LINE_SE1) begin
         state_d    = ERROR;
         rx_error_d = 1'b1;
      end else begin
         case (state_q)
            IDLE: begin
               if (d_plus_prev && line == LINE_K) begin
                  state_d    = SYNC;
                  sr_d       = '0;
                  bit_cnt_d  = '0;
                  ones_cnt_d = '0;
                  rx_error_d = 1'b0;
                  se0_seen_d = 1'b0;
               end
            end
            SYNC: begin
               if (eop_d1_q) begin
                  state_d    = ERROR;
                  rx_error_d = 1'b1;
               end else if (shift_d1_q) begin
                  sr_d      = sr_shift;
                  bit_cnt_d = bit_cnt_q + 3'd1;
                  if (bit_cnt_q == 3'd7) begin
                     bit_cnt_d = '0;
                     if (sr_shift == SYNC_PATTERN) begin
                        state_d    = RECEIVE;
                        ones_cnt_d = 3'd1;
                     end else begin
                        state_d    = ERROR;
                        rx_error_d = 1'b1;
                     end
                  end
               end
            end
            RECEIVE: begin
               // SE0 wins over a data bit decoded in the same cycle
               if (eop_d1_q) begin
                  if (bit_cnt_q == 3'd0) begin
                     state_d = EOP_WAIT;
                  end else begin
                     state_d    = ERROR;
                     rx_error_d = 1'b1;
                  end
               end else if (shift_d1_q) begin
                  if (ones_cnt_q == STUFF_LIMIT) begin
                     if (d_orig) begin
                        state_d    = ERROR;
                        rx_error_d = 1'b1;
                     end else begin
                        ones_cnt_d = '0;
                     end
                  end else begin
                     sr_d       = sr_shift;
                     ones_cnt_d = d_orig ? ones_cnt_q + 3'd1 : 3'd0;
                     if (bit_cnt_q == 3'd7) begin
                        bit_cnt_d    = '0;
                        rcv_data_d   = sr_shift;
                        byte_valid_d = 1'b1;
                     end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                     end
                  end
               end
            end
            EOP_WAIT: begin
               if (line == LINE_J) begin
                  state_d       = IDLE;
                  packet_done_d = 1'b1;
               end
            end
            ERROR: begin
               if (line == LINE_SE0) begin
                  se0_seen_d = 1'b1;
               end else if (se0_seen_q && line == LINE_J) begin
                  state_d = IDLE;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= IDLE;
         sr_q          <= '0;
         rcv_data_q    <= '0;
         bit_cnt_q     <= '0;
         ones_cnt_q    <= '0;
         byte_valid_q  <= 1'b0;
         packet_done_q <= 1'b0;
         rx_error_q    <= 1'b0;
         se0_seen_q    <= 1'b0;
         shift_d1_q    <= 1'b0;
         eop_d1_q      <= 1'b0;
      end else begin
         state_q       <= state_d;
         sr_q          <= sr_d;
         rcv_data_q    <= rcv_data_d;
         bit_cnt_q     <= bit_cnt_d;
         ones_cnt_q    <= ones_cnt_d;
         byte_valid_q  <= byte_valid_d;
         packet_done_q <= packet_done_d;
         rx_error_q    <= rx_error_d;
         se0_seen_q    <= se0_seen_d;
         shift_d1_q    <= shift_en;
         eop_d1_q      <= eop & shift_en;
      end
   end

endmodule

// File: tb/tb_usb_rx_controller.sv
// tb/tb_usb_rx_controller.sv - scoreboard bench driving NRZI line levels through a decoder model
module tb_usb_rx_controller;

   logic       clk;
   logic       rst;
   logic       dp;
   logic       dm;
   logic       d_orig;
   logic       shift_en;
   logic       eop;
   logic [7:0] rcv_data;
   logic       byte_valid;
   logic       receiving;
   logic       packet_done;
   logic       rx_error;

   int checks   = 0;
   int failures = 0;

   logic [8:0] exp_q[$];
   logic [8:0] exp_item;
   logic       lvl;
   logic       dec_prev;

   localparam logic [8:0] EXP_DONE = 9'h100;

   usb_rx_controller #(.CLKS_PER_BIT(8), .SAMPLE_POINT(3)) dut (
      .clk          (clk),
      .rst          (rst),
      .d_plus_sync  (dp),
      .d_minus_sync (dm),
      .d_orig       (d_orig),
      .shift_en     (shift_en),
      .eop          (eop),
      .rcv_data     (rcv_data),
      .byte_valid   (byte_valid),
      .receiving    (receiving),
      .packet_done  (packet_done),
      .rx_error     (rx_error)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // NRZI decoder: a held level is a 1, a transition is a 0; SE0 re-arms it to idle J
   always @(posedge clk) begin
      if (rst) begin
         dec_prev <= 1'b1;
         d_orig   <= 1'b0;
      end else if (shift_en) begin
         if (eop) begin
            dec_prev <= 1'b1;
            d_orig   <= 1'b0;
         end else begin
            d_orig   <= (dp == dec_prev);
            dec_prev <= dp;
         end
      end
   end

   always @(negedge clk) begin
      if (!rst && byte_valid) begin
         checks++;
         if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL byte_unexpected: got rcv_data=%h, required no byte", rcv_data);
         end else begin
            exp_item = exp_q.pop_front();
            if ({1'b0, rcv_data} !== exp_item) begin
               failures++;
               $display("FAIL byte_data: got %h, required %h", {1'b0, rcv_data}, exp_item);
            end
         end
      end
      if (!rst && packet_done) begin
         checks++;
         if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL done_unexpected: got packet_done=1, required no pulse");
         end else begin
            exp_item = exp_q.pop_front();
            if (exp_item !== EXP_DONE) begin
               failures++;
               $display("FAIL done_order: got packet_done, required %h", exp_item);
            end
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h, required %0h", name, act, exp);
      end
   endtask

   task automatic send_bit(input logic b, input int n);
      if (!b) lvl = ~lvl;
      dp = lvl;
      dm = ~lvl;
      repeat (n) @(negedge clk);
   endtask

   task automatic send_bits(input logic [31:0] v, input int n);
      for (int i = 0; i < n; i++) send_bit(v[i], 8);
   endtask

   task automatic send_eop();
      dp = 1'b0;
      dm = 1'b0;
      @(negedge clk);
      chk("eop_during_se0", 32'(eop), 32'd1);
      repeat (15) @(negedge clk);
      dp = 1'b1;
      dm = 1'b0;
      lvl = 1'b1;
      repeat (16) @(negedge clk);
   endtask

   initial begin
      rst = 1'b1;
      dp  = 1'b1;
      dm  = 1'b0;
      lvl = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("rst_shift_en",    32'(shift_en),    32'd0);
      chk("rst_rcv_data",    32'(rcv_data),    32'd0);
      chk("rst_byte_valid",  32'(byte_valid),  32'd0);
      chk("rst_receiving",   32'(receiving),   32'd0);
      chk("rst_packet_done", 32'(packet_done), 32'd0);
      chk("rst_rx_error",    32'(rx_error),    32'd0);
      chk("idle_eop",        32'(eop),         32'd0);

      // Reset three clocks into the 8th data bit, before it is sampled
      send_bits(32'h80, 8);
      chk("sync_receiving", 32'(receiving), 32'd1);
      send_bits(32'h78, 7);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("midrst_receiving", 32'(receiving), 32'd0);
      repeat (16) @(negedge clk);
      chk("midrst_idle", 32'(receiving), 32'd0);

      // Single byte packet
      exp_q.push_back(9'h0A5);
      exp_q.push_back(EXP_DONE);
      send_bits(32'h80, 8);
      send_bits(32'hA5, 8);
      send_eop();
      chk("a5_rx_error",  32'(rx_error),  32'd0);
      chk("a5_receiving", 32'(receiving), 32'd0);

      // 0xFF then 0x01, one stuffed 0 after the sixth consecutive 1
      exp_q.push_back(9'h0FF);
      exp_q.push_back(9'h001);
      exp_q.push_back(EXP_DONE);
      send_bits(32'h80, 8);
      send_bits(32'h003DF, 17);
      send_eop();
      chk("stuff_ok_rx_error", 32'(rx_error), 32'd0);

      // Seventh consecutive 1 is a stuff violation
      send_bits(32'h80, 8);
      send_bits(32'h3F, 6);
      chk("stuff_err_flag", 32'(rx_error), 32'd1);
      send_eop();
      chk("stuff_err_held",  32'(rx_error),  32'd1);
      chk("stuff_err_idle",  32'(receiving), 32'd0);

      // Corrupted SYNC (decodes to 8'hC0), data following it is ignored
      send_bits(32'hC0, 8);
      chk("bad_sync_flag", 32'(rx_error), 32'd1);
      send_bits(32'hA5, 8);
      chk("bad_sync_held", 32'(rx_error), 32'd1);
      send_eop();
      chk("bad_sync_idle",  32'(receiving), 32'd0);
      chk("bad_sync_after", 32'(rx_error),  32'd1);

      // SE0 after three data bits
      send_bits(32'h80, 8);
      send_bits(32'h5, 3);
      send_eop();
      chk("short_eop_flag", 32'(rx_error),  32'd1);
      chk("short_eop_idle", 32'(receiving), 32'd0);

      // One bit stretched to nine clocks; the timer must resync
      exp_q.push_back(9'h0A5);
      exp_q.push_back(EXP_DONE);
      send_bits(32'h80, 8);
      chk("new_sync_clears_err", 32'(rx_error), 32'd0);
      for (int i = 0; i < 8; i++) send_bit(1'((32'hA5 >> i) & 32'd1), (i == 2) ? 9 : 8);
      send_eop();
      chk("jitter_rx_error", 32'(rx_error), 32'd0);

      repeat (8) @(negedge clk);
      chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
